// File: rtl/pipeline_pkg.sv
// Shared decode-stage types: opcode/funct constants, ALU/memory op enums,
// the decoded-op struct handed to EX, and immediate/operand helpers.
package pipeline_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Integer ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  // Load/store width funct3
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;
  // Multiply/divide funct3
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [4:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
    ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC, ALU_JAL, ALU_JALR,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_SYS
  } alu_op_e;

  typedef enum logic [3:0] {
    MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br_pred;
  } fetch_t;

  typedef struct packed {
    alu_op_e           alu_op;
    mem_op_e           mem_op;
    logic [REG_AW-1:0] rd;
    logic              wb_en;
    logic [XLEN-1:0]   imm;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              illegal;
  } dec_t;

  typedef struct packed {
    alu_op_e           alu_op;
    mem_op_e           mem_op;
    logic [REG_AW-1:0] rd;
    logic              wb_en;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [31:0]       pc;
    logic              br_pred;
    logic              illegal;
  } id_op_t;

  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // A writeback landing this cycle is newer than the regfile read port.
  function automatic logic [XLEN-1:0] read_operand(
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   rf_data,
    input logic              wb_en,
    input logic [REG_AW-1:0] wb_rd,
    input logic [XLEN-1:0]   wb_data
  );
    if (rs == '0) return '0;
    if (wb_en && (wb_rd == rs)) return wb_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Generic valid/ack handshake carrying a flat payload; the master drives
// valid/data, the slave answers with ack in the same cycle.
interface id_stage_if #(
  parameter int unsigned WIDTH = 1
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ack;

  modport master (output valid, output data, input ack);
  modport slave  (input valid, input data, output ack);
endinterface

// File: rtl/id_stage_decoder.sv
// Purely combinational RV32I instruction decoder. Define RV32M_EN to decode
// the multiply/divide group; otherwise those encodings are illegal.
module id_stage_decoder
  import pipeline_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [REG_AW-1:0] rd_f;
  logic              writes;
  logic              legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rd_f   = instr[11:7];

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    dec    = '0;
    writes = 1'b0;
    legal  = 1'b1;
    case (opcode)
      OPC_LUI:   begin dec.alu_op = ALU_LUI;   dec.imm = imm_u(instr); writes = 1'b1; end
      OPC_AUIPC: begin dec.alu_op = ALU_AUIPC; dec.imm = imm_u(instr); writes = 1'b1; end
      OPC_JAL:   begin dec.alu_op = ALU_JAL;   dec.imm = imm_j(instr); writes = 1'b1; end
      OPC_JALR: begin
        dec.alu_op   = ALU_JALR;
        dec.imm      = imm_i(instr);
        dec.uses_rs1 = 1'b1;
        writes       = 1'b1;
        legal        = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        dec.imm      = imm_b(instr);
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
        case (f3)
          F3_BEQ:  dec.alu_op = ALU_BEQ;
          F3_BNE:  dec.alu_op = ALU_BNE;
          F3_BLT:  dec.alu_op = ALU_BLT;
          F3_BGE:  dec.alu_op = ALU_BGE;
          F3_BLTU: dec.alu_op = ALU_BLTU;
          F3_BGEU: dec.alu_op = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec.alu_op   = ALU_ADD;
        dec.imm      = imm_i(instr);
        dec.uses_rs1 = 1'b1;
        writes       = 1'b1;
        case (f3)
          F3_B:    dec.mem_op = MEM_LB;
          F3_H:    dec.mem_op = MEM_LH;
          F3_W:    dec.mem_op = MEM_LW;
          F3_BU:   dec.mem_op = MEM_LBU;
          F3_HU:   dec.mem_op = MEM_LHU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        dec.alu_op   = ALU_ADD;
        dec.imm      = imm_s(instr);
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
        case (f3)
          F3_B:    dec.mem_op = MEM_SB;
          F3_H:    dec.mem_op = MEM_SH;
          F3_W:    dec.mem_op = MEM_SW;
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec.imm      = imm_i(instr);
        dec.uses_rs1 = 1'b1;
        writes       = 1'b1;
        case (f3)
          F3_ADD:  dec.alu_op = ALU_ADD;
          F3_SLT:  dec.alu_op = ALU_SLT;
          F3_SLTU: dec.alu_op = ALU_SLTU;
          F3_XOR:  dec.alu_op = ALU_XOR;
          F3_OR:   dec.alu_op = ALU_OR;
          F3_AND:  dec.alu_op = ALU_AND;
          F3_SLL: begin
            dec.alu_op = ALU_SLL;
            legal      = (f7 == F7_BASE);
          end
          F3_SR: begin
            if (f7 == F7_BASE)     dec.alu_op = ALU_SRL;
            else if (f7 == F7_ALT) dec.alu_op = ALU_SRA;
            else                   legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP: begin
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
        writes       = 1'b1;
        case (f7)
          F7_BASE: begin
            case (f3)
              F3_ADD:  dec.alu_op = ALU_ADD;
              F3_SLL:  dec.alu_op = ALU_SLL;
              F3_SLT:  dec.alu_op = ALU_SLT;
              F3_SLTU: dec.alu_op = ALU_SLTU;
              F3_XOR:  dec.alu_op = ALU_XOR;
              F3_SR:   dec.alu_op = ALU_SRL;
              F3_OR:   dec.alu_op = ALU_OR;
              F3_AND:  dec.alu_op = ALU_AND;
              default: legal = 1'b0;
            endcase
          end
          F7_ALT: begin
            case (f3)
              F3_ADD:  dec.alu_op = ALU_SUB;
              F3_SR:   dec.alu_op = ALU_SRA;
              default: legal = 1'b0;
            endcase
          end
          F7_MULDIV: begin
`ifdef RV32M_EN
            case (f3)
              F3_MUL:    dec.alu_op = ALU_MUL;
              F3_MULH:   dec.alu_op = ALU_MULH;
              F3_MULHSU: dec.alu_op = ALU_MULHSU;
              F3_MULHU:  dec.alu_op = ALU_MULHU;
              F3_DIV:    dec.alu_op = ALU_DIV;
              F3_DIVU:   dec.alu_op = ALU_DIVU;
              F3_REM:    dec.alu_op = ALU_REM;
              F3_REMU:   dec.alu_op = ALU_REMU;
              default:   legal = 1'b0;
            endcase
`else
            legal = 1'b0;
`endif
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_MISC_MEM: dec.alu_op = ALU_NOP;
      OPC_SYSTEM: begin
        dec.alu_op = ALU_SYS;
        legal      = (f3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase

    // rd only matters for ops that write; x0 destinations never claim the scoreboard.
    if (legal) begin
      dec.rd    = writes ? rd_f : '0;
      dec.wb_en = writes && (rd_f != '0);
    end else begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: fetch handshake in, scoreboarded hazard check,
// writeback bypass and a registered decoded op out to EX. Optional: RV32M_EN.
module id_stage
  import pipeline_pkg::*;
(
  input  logic              clk,
  input  logic              rstn_i,
  input  logic              flush_i,
  input  logic              halt_i,
  id_stage_if.slave         fetch,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  id_stage_if.master        ex
);

  fetch_t           in_op;
  dec_t             dec;
  id_op_t           new_op;
  id_op_t           op_q, op_d;
  logic             valid_q, valid_d;
  logic [NREGS-1:0] sb_q, sb_d;
  logic [NREGS-1:0] wb_mask;
  logic [NREGS-1:0] busy;
  logic             hazard;
  logic             accept;

  assign in_op = fetch_t'(fetch.data);

  id_stage_decoder u_decoder (
    .instr (in_op.instr),
    .dec   (dec)
  );

  assign rs1_addr_o = in_op.instr[19:15];
  assign rs2_addr_o = in_op.instr[24:20];

  // A register whose writeback lands this cycle is already free; sb_q[0] never sets.
  assign wb_mask = wb_en_i ? (NREGS'(1) << wb_rd_i) : '0;
  assign busy    = sb_q & ~wb_mask;
  assign hazard  = (dec.uses_rs1 & busy[rs1_addr_o])
                 | (dec.uses_rs2 & busy[rs2_addr_o])
                 | (dec.wb_en    & busy[dec.rd]);

  assign accept = rstn_i & fetch.valid & (!valid_q | ex.ack)
                & !hazard & !flush_i & !halt_i;
  assign fetch.ack = accept;

  always_comb begin
    new_op          = '0;
    new_op.alu_op   = dec.alu_op;
    new_op.mem_op   = dec.mem_op;
    new_op.rd       = dec.rd;
    new_op.wb_en    = dec.wb_en;
    new_op.imm      = dec.imm;
    new_op.rs1_data = dec.uses_rs1
                    ? read_operand(rs1_addr_o, rs1_data_i, wb_en_i, wb_rd_i, wb_data_i) : '0;
    new_op.rs2_data = dec.uses_rs2
                    ? read_operand(rs2_addr_o, rs2_data_i, wb_en_i, wb_rd_i, wb_data_i) : '0;
    new_op.pc       = in_op.pc;
    new_op.br_pred  = in_op.br_pred;
    new_op.illegal  = dec.illegal;
  end

  // Writeback clears first so an accept to the same register wins.
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    sb_d    = sb_q & ~wb_mask;
    if (accept) begin
      valid_d = 1'b1;
      op_d    = new_op;
      if (dec.wb_en) sb_d[dec.rd] = 1'b1;
    end else if (flush_i) begin
      valid_d = 1'b0;
      // A held op that EX consumes this same cycle is not killed and keeps its bit.
      if (valid_q && op_q.wb_en && !ex.ack) sb_d[op_q.rd] = 1'b0;
    end else if (!halt_i && ex.ack) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the scoreboard is a flop vector, not a RAM, so it resets with the rest of the stage.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      sb_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      valid_q <= valid_d;
      op_q    <= op_d;
      sb_q    <= sb_d;
    end
  end

  assign ex.valid = valid_q;
  assign ex.data  = op_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: handshake, hazards, bypass,
// flush/halt, immediates, illegal/RV32M decode and asynchronous reset.
module tb_id_stage;
  import pipeline_pkg::*;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              flush = 1'b0;
  logic              halt = 1'b0;
  logic [REG_AW-1:0] rs1_addr, rs2_addr;
  logic [XLEN-1:0]   rs1_data, rs2_data;
  logic              wb_en = 1'b0;
  logic [REG_AW-1:0] wb_rd = '0;
  logic [XLEN-1:0]   wb_data = '0;

  int errors = 0;
  int checks = 0;

  id_stage_if #(.WIDTH($bits(fetch_t))) fetch_if ();
  id_stage_if #(.WIDTH($bits(id_op_t))) ex_if ();

  // Register file stand-in: xN reads as 0x1000 + N.
  assign rs1_data = 32'h1000 + 32'(rs1_addr);
  assign rs2_data = 32'h1000 + 32'(rs2_addr);

  always #5 clk = ~clk;

  id_stage dut (
    .clk        (clk),
    .rstn_i     (rstn),
    .flush_i    (flush),
    .halt_i     (halt),
    .fetch      (fetch_if),
    .rs1_addr_o (rs1_addr),
    .rs2_addr_o (rs2_addr),
    .rs1_data_i (rs1_data),
    .rs2_data_i (rs2_data),
    .wb_en_i    (wb_en),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_data),
    .ex         (ex_if)
  );

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic bp);
    fetch_if.valid = v;
    fetch_if.data  = {instr, pc, bp};
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    wb_en   = en;
    wb_rd   = rd;
    wb_data = data;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic id_op_t mk(input alu_op_e a, input mem_op_e m, input logic [4:0] rd,
                                input logic wbe, input logic [31:0] imm,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] pc, input logic bp, input logic ill);
    id_op_t o;
    o = '0;
    o.alu_op = a; o.mem_op = m; o.rd = rd; o.wb_en = wbe; o.imm = imm;
    o.rs1_data = r1; o.rs2_data = r2; o.pc = pc; o.br_pred = bp; o.illegal = ill;
    return o;
  endfunction

  task automatic check_ack(input string tag, input logic exp);
    #1;
    check(tag, 160'(fetch_if.ack), 160'(exp));
  endtask

  task automatic check_out(input string tag, input logic v, input id_op_t op, input logic [31:0] sb);
    check({tag, ".valid"}, 160'(ex_if.valid), 160'(v));
    if (v) check({tag, ".op"}, 160'(ex_if.data), 160'(op));
    check({tag, ".sb"}, 160'(dut.sb_q), 160'(sb));
  endtask

  id_op_t exp_mul;

  initial begin
    ex_if.ack = 1'b0;
    send(1'b1, 32'h00500093, 32'h100, 1'b0);
    step; step;
    // Reset state, including no ack even with an op on offer
    check("rst.ack", 160'(fetch_if.ack), 160'(0));
    check("rst.op", 160'(ex_if.data), 160'(0));
    check_out("rst", 1'b0, '0, 32'h0);

    // 1: ADDI x1,x0,5 accepted in the release cycle
    rstn = 1'b1;
    ex_if.ack = 1'b1;
    check_ack("t1.ack", 1'b1);
    step;
    check_out("t1", 1'b1, mk(ALU_ADD, MEM_NONE, 5'd1, 1'b1, 32'd5, 0, 0, 32'h100, 1'b0, 1'b0),
              32'h2);

    // 2: ADD x2,x1,x1 stalls on x1, then goes with the bypassed writeback
    send(1'b1, 32'h00108133, 32'h104, 1'b0);
    check_ack("t2.stall", 1'b0);
    check("t2.rs1_addr", 160'(rs1_addr), 160'(1));
    check("t2.rs2_addr", 160'(rs2_addr), 160'(1));
    step;
    check_out("t2.drain", 1'b0, '0, 32'h2);
    wb(1'b1, 5'd1, 32'd7);
    check_ack("t2.go", 1'b1);
    step;
    check_out("t2", 1'b1, mk(ALU_ADD, MEM_NONE, 5'd2, 1'b1, 0, 32'd7, 32'd7, 32'h104, 1'b0, 1'b0),
              32'h4);
    wb(1'b0, 5'd0, 32'd0);

    // 3: EX back-pressure holds op_o bit-identical for three cycles
    ex_if.ack = 1'b0;
    send(1'b1, 32'h00100213, 32'h108, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_ack("t3.ack", 1'b0);
      step;
      check_out("t3.hold", 1'b1,
                mk(ALU_ADD, MEM_NONE, 5'd2, 1'b1, 0, 32'd7, 32'd7, 32'h104, 1'b0, 1'b0), 32'h4);
    end

    // 4: LW x3,8(x0) held, then flushed
    ex_if.ack = 1'b1;
    send(1'b1, 32'h00802183, 32'h10C, 1'b0);
    check_ack("t4.lw_ack", 1'b1);
    step;
    check_out("t4.lw", 1'b1, mk(ALU_ADD, MEM_LW, 5'd3, 1'b1, 32'd8, 0, 0, 32'h10C, 1'b0, 1'b0),
              32'hC);
    ex_if.ack = 1'b0;
    flush = 1'b1;
    send(1'b1, 32'h00100213, 32'h110, 1'b0);
    check_ack("t4.flush_ack", 1'b0);
    step;
    check_out("t4.flush", 1'b0, '0, 32'h4);
    flush = 1'b0;

    // 5: MUL x0,x1,x2 after x2 retires
    send(1'b0, 32'h0, 32'h0, 1'b0);
    wb(1'b1, 5'd2, 32'h22);
    step;
    check_out("t5.wb", 1'b0, '0, 32'h0);
    wb(1'b0, 5'd0, 32'd0);
    ex_if.ack = 1'b1;
    send(1'b1, 32'h02208033, 32'h110, 1'b0);
    check_ack("t5.ack", 1'b1);
    step;
`ifdef RV32M_EN
    exp_mul = mk(ALU_MUL, MEM_NONE, 5'd0, 1'b0, 0, 32'h1001, 32'h1002, 32'h110, 1'b0, 1'b0);
`else
    exp_mul = mk(ALU_NOP, MEM_NONE, 5'd0, 1'b0, 0, 0, 0, 32'h110, 1'b0, 1'b1);
`endif
    check_out("t5", 1'b1, exp_mul, 32'h0);

    // 6: four independent ADDIs back to back; x4 retires during the third
    send(1'b1, 32'h00100213, 32'h200, 1'b0);
    check_ack("t6.a0", 1'b1);
    step;
    check_out("t6.x4", 1'b1, mk(ALU_ADD, MEM_NONE, 5'd4, 1'b1, 32'd1, 0, 0, 32'h200, 1'b0, 1'b0),
              32'h10);
    send(1'b1, 32'h00200293, 32'h204, 1'b1);
    check_ack("t6.a1", 1'b1);
    step;
    check_out("t6.x5", 1'b1, mk(ALU_ADD, MEM_NONE, 5'd5, 1'b1, 32'd2, 0, 0, 32'h204, 1'b1, 1'b0),
              32'h30);
    send(1'b1, 32'h00300313, 32'h208, 1'b0);
    wb(1'b1, 5'd4, 32'h44);
    check_ack("t6.a2", 1'b1);
    step;
    check_out("t6.x6", 1'b1, mk(ALU_ADD, MEM_NONE, 5'd6, 1'b1, 32'd3, 0, 0, 32'h208, 1'b0, 1'b0),
              32'h60);
    wb(1'b0, 5'd0, 32'd0);
    send(1'b1, 32'hFFF00393, 32'h20C, 1'b1);
    check_ack("t6.a3", 1'b1);
    step;
    check_out("t6.x7", 1'b1,
              mk(ALU_ADD, MEM_NONE, 5'd7, 1'b1, 32'hFFFFFFFF, 0, 0, 32'h20C, 1'b1, 1'b0), 32'hE0);

    // 7: immediate boundaries, flush together with ack, illegal, WAW stall
    send(1'b1, 32'hFE000EE3, 32'h300, 1'b1);
    step;
    check_out("t7.beq", 1'b1,
              mk(ALU_BEQ, MEM_NONE, 5'd0, 1'b0, 32'hFFFFFFFC, 0, 0, 32'h300, 1'b1, 1'b0), 32'hE0);
    send(1'b1, 32'h12345437, 32'h304, 1'b0);
    step;
    check_out("t7.lui", 1'b1,
              mk(ALU_LUI, MEM_NONE, 5'd8, 1'b1, 32'h12345000, 0, 0, 32'h304, 1'b0, 1'b0), 32'h1E0);
    flush = 1'b1;
    send(1'b1, 32'hFE002FA3, 32'h308, 1'b0);
    check_ack("t7.flush_ack", 1'b0);
    step;
    check_out("t7.flush_consumed", 1'b0, '0, 32'h1E0);
    flush = 1'b0;
    check_ack("t7.sw_ack", 1'b1);
    step;
    check_out("t7.sw", 1'b1,
              mk(ALU_ADD, MEM_SW, 5'd0, 1'b0, 32'hFFFFFFFF, 0, 0, 32'h308, 1'b0, 1'b0), 32'h1E0);
    send(1'b1, 32'h00000000, 32'h30C, 1'b0);
    step;
    check_out("t7.illegal", 1'b1, mk(ALU_NOP, MEM_NONE, 5'd0, 1'b0, 0, 0, 0, 32'h30C, 1'b0, 1'b1),
              32'h1E0);
    send(1'b1, 32'hFFF00393, 32'h310, 1'b0);
    check_ack("t7.waw", 1'b0);
    step;
    check_out("t7.waw", 1'b0, '0, 32'h1E0);
    send(1'b1, 32'h00100213, 32'h314, 1'b0);
    step;
    check_out("t7.x4", 1'b1, mk(ALU_ADD, MEM_NONE, 5'd4, 1'b1, 32'd1, 0, 0, 32'h314, 1'b0, 1'b0),
              32'h1F0);

    // 8: halt freezes the stage while writebacks still clear the scoreboard
    halt = 1'b1;
    send(1'b1, 32'hFE000EE3, 32'h318, 1'b0);
    wb(1'b1, 5'd5, 32'h55);
    check_ack("t8.halt_ack", 1'b0);
    step;
    check_out("t8.halt", 1'b1, mk(ALU_ADD, MEM_NONE, 5'd4, 1'b1, 32'd1, 0, 0, 32'h314, 1'b0, 1'b0),
              32'h1D0);
    halt = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    ex_if.ack = 1'b0;

    // 9: asynchronous reset mid-operation
    #2;
    rstn = 1'b0;
    #1;
    check("t9.ack", 160'(fetch_if.ack), 160'(0));
    check("t9.op", 160'(ex_if.data), 160'(0));
    check_out("t9", 1'b0, '0, 32'h0);
    rstn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
